// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial ripple subtractor: FSM state encoding,
// default operand width and the counter-width helper.
package serial_ripple_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Smallest number of bits able to index 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo set when the bit borrows.
// Serial counterpart of the library full_adder cell.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference and borrow of one bit position.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// through a single full_subtractor cell with a registered borrow.
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d_bit;
  logic             bo_bit;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, pulse DONE once.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == LAST_BIT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath: operand capture, bit-per-cycle shift, result publication.
  // NOTE: every datapath register is reset so an aborted operation leaves no
  // stale operand, borrow or partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      brw    <= bo_bit;
      res_sh <= {d_bit, res_sh[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      // Publish only the completed word so partial results never leak out.
      if (last_bit) begin
        diff <= {d_bit, res_sh[WIDTH-1:1]};
        bout <= bo_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor at WIDTH=4 and WIDTH=16.
// Expected results come from plain integer arithmetic on a - b - bin.
module tb_serial_ripple_subtractor;

  localparam int W4  = 4;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic rst;

  logic           start4, bin4, ready4, done4, bout4;
  logic [W4-1:0]  a4, b4, diff4;
  logic           start16, bin16, ready16, done16, bout16;
  logic [W16-1:0] a16, b16, diff16;

  int n_checks = 0;
  int n_fail   = 0;

  // Model-side record of what diff/bout must currently be holding.
  logic [W4-1:0]  held_diff4;
  logic           held_bout4;
  logic [W16-1:0] held_diff16;
  logic           held_bout16;

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(W4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .ready (ready4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  serial_ripple_subtractor #(.WIDTH(W16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .bin   (bin16),
    .ready (ready16),
    .done  (done16),
    .diff  (diff16),
    .bout  (bout16)
  );

  // One full 4-bit operation starting at a negedge where ready must be high.
  // Ends at the negedge where ready has returned high. With noisy set, inputs
  // and start are scrambled every cycle after acceptance.
  task automatic run_op4(input logic [W4-1:0] av, input logic [W4-1:0] bv,
                         input logic binv, input bit noisy);
    int            e;
    logic [W4-1:0] exp_d;
    logic          exp_b;
    logic [W4+2:0] obs, want;
    e     = int'(av) - int'(bv) - int'(binv);
    exp_d = e[W4-1:0];
    exp_b = (e < 0);
    n_checks++;
    if (ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL op4_ready_idle a=%0d b=%0d: got %b want 1", av, bv, ready4);
    end
    start4 = 1'b1; a4 = av; b4 = bv; bin4 = binv;
    for (int n = 1; n <= W4 + 1; n++) begin
      @(negedge clk);
      if (noisy) begin
        start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      end else begin
        start4 = 1'b0;
      end
      obs = {done4, ready4, bout4, diff4};
      if (n <= W4) want = {1'b0, 1'b0, held_bout4, held_diff4};
      else         want = {1'b1, 1'b0, exp_b, exp_d};
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL op4_cycle%0d a=%0d b=%0d bin=%0d: {done,ready,bout,diff} got %b want %b",
                 n, av, bv, binv, obs, want);
      end
    end
    @(negedge clk);
    start4 = 1'b0;
    obs  = {done4, ready4, bout4, diff4};
    want = {1'b0, 1'b1, exp_b, exp_d};
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL op4_after_done a=%0d b=%0d bin=%0d: got %b want %b", av, bv, binv, obs, want);
    end
    held_diff4 = exp_d;
    held_bout4 = exp_b;
  endtask

  // Same protocol for the 16-bit instance.
  task automatic run_op16(input logic [W16-1:0] av, input logic [W16-1:0] bv, input logic binv);
    int             e;
    logic [W16-1:0] exp_d;
    logic           exp_b;
    logic [W16+2:0] obs, want;
    e     = int'(av) - int'(bv) - int'(binv);
    exp_d = e[W16-1:0];
    exp_b = (e < 0);
    start16 = 1'b1; a16 = av; b16 = bv; bin16 = binv;
    for (int n = 1; n <= W16 + 2; n++) begin
      @(negedge clk);
      start16 = 1'b0;
      obs = {done16, ready16, bout16, diff16};
      if (n <= W16)          want = {1'b0, 1'b0, held_bout16, held_diff16};
      else if (n == W16 + 1) want = {1'b1, 1'b0, exp_b, exp_d};
      else                   want = {1'b0, 1'b1, exp_b, exp_d};
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL op16_cycle%0d a=%h b=%h bin=%0d: {done,ready,bout,diff} got %h want %h",
                 n, av, bv, binv, obs, want);
      end
    end
    held_diff16 = exp_d;
    held_bout16 = exp_b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({done4, ready4, bout4, diff4} !== 7'b0100000) begin
      n_fail++;
      $display("FAIL reset4: got %b want 0100000", {done4, ready4, bout4, diff4});
    end
    n_checks++;
    if ({done16, ready16, bout16, diff16} !== {3'b010, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset16: got %h want %h", {done16, ready16, bout16, diff16}, {3'b010, 16'h0000});
    end
    rst = 1'b0;
    held_diff4 = '0; held_bout4 = 1'b0;
    held_diff16 = '0; held_bout16 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op4(4'd9, 4'd3, 1'b0, 1'b0);
  endtask

  task automatic test_borrow_cases();
    run_op4(4'd3, 4'd9, 1'b0, 1'b0);
    run_op4(4'd0, 4'd0, 1'b1, 1'b0);
    run_op4(4'd15, 4'd15, 1'b1, 1'b0);
    run_op4(4'd7, 4'd7, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_op4(4'd9, 4'd3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({done4, ready4, bout4, diff4} !== {2'b01, 1'b0, 4'd6}) begin
        n_fail++;
        $display("FAIL ignored_start_idle%0d: got %b want %b", i, {done4, ready4, bout4, diff4},
                 {2'b01, 1'b0, 4'd6});
      end
    end
  endtask

  task automatic test_mid_reset();
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({done4, ready4, bout4, diff4} !== 7'b0100000) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got %b want 0100000", {done4, ready4, bout4, diff4});
    end
    @(negedge clk);
    rst = 1'b0;
    held_diff4 = '0; held_bout4 = 1'b0;
    held_diff16 = '0; held_bout16 = 1'b0;
    for (int i = 0; i < W4 + 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({done4, ready4, bout4, diff4} !== 7'b0100000) begin
        n_fail++;
        $display("FAIL mid_reset_quiet%0d: got %b want 0100000", i, {done4, ready4, bout4, diff4});
      end
    end
    run_op4(4'd12, 4'd5, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op4(4'd9, 4'd3, 1'b0, 1'b0);
    run_op4(4'd1, 4'd2, 1'b0, 1'b0);
    run_op4(4'd14, 4'd2, 1'b1, 1'b0);
  endtask

  task automatic test_sweep();
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bi = 0; bi < 2; bi++)
          run_op4(4'(av), 4'(bv), 1'(bi), 1'b0);
    run_op16(16'h0000, 16'h0000, 1'b1);
    run_op16(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 1000; i++)
      run_op16(16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_cases();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
Bit-serial counterpart to the team's parallel ripple-carry adder. Computes a - b - bin one bit per clock through a single full-subtractor cell, with a registered borrow that ripples across cycles. It sits beside the parallel adder in the arithmetic library, for datapaths that trade latency for area. A start/ready/done handshake launches operands and reports the result.

Parameters:
WIDTH, 4, operand and difference width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while ready=1
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
ready  output  1  high in IDLE; block can accept start
done  output  1  single-cycle pulse; diff/bout valid from this cycle on
diff  output  WIDTH  registered difference, (a - b - bin) mod 2^WIDTH
bout  output  1  registered borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (asynchronous assert, released synchronously to clk): state=IDLE, ready=1, done=0, diff=0, bout=0, all internal shift registers, bit counter and borrow register cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. If start=1 at a rising edge: latch a, b and the internal borrow register <= bin, counter <= 0, go to RUN. ready drops in the next cycle.
- RUN: ready=0. Each cycle:
  - d = a_sh[0] ^ b_sh[0] ^ brw
  - brw <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw)
  - a_sh and b_sh shift right by 1
  - d shifts into the MSB of the internal result shift register
  - counter increments
  - After WIDTH RUN cycles (counter == WIDTH-1 at the edge): load diff <= completed result and bout <= final borrow, then go to DONE.
- DONE: done=1 for exactly one cycle, ready=0, then go to IDLE.
- Latency: start accepted at edge T; done high in the cycle after edge T+WIDTH; next start accepted at edge T+WIDTH+2 at the earliest.
- diff and bout change only on the RUN->DONE transition and hold their values until the next completion or reset. They never expose partial results.
- start while ready=0 (RUN or DONE) is ignored, with no queueing. a, b and bin may change freely after acceptance.
- Reset mid-operation aborts the operation: outputs return to reset values and no done pulse is produced.
- Boundary cases:
  - a=b with bin=0 gives diff=0, bout=0.
  - a=0 with b=0 and bin=1 gives diff = all ones, bout=1.
  - Wrap-around is modulo 2^WIDTH.
  - There is no overflow flag. Signed interpretation is the user's responsibility.

Decomposition:
- Shared arithmetic package: FSM state typedef (IDLE/RUN/DONE), counter-width function clog2(WIDTH), default WIDTH constant.
- One sub-module: full_subtractor (inputs x, y, bi; outputs d, bo; purely combinational). It is instantiated once and is the serial counterpart of the existing full_adder cell.

Test Plan:
1. WIDTH=4, a=9, b=3, bin=0, one start pulse -> ready low for 5 cycles; done pulses exactly once in the 5th cycle after the start edge; diff=6, bout=0; ready returns high the next cycle.
2. a=3, b=9, bin=0 -> diff=4'hA, bout=1. Then a=0, b=0, bin=1 -> diff=4'hF, bout=1. Then a=15, b=15, bin=1 -> diff=4'hF, bout=1.
3. Issue start with a=9, b=3; change a/b every cycle and pulse start again during RUN and during DONE -> exactly one done pulse, diff=6; the extra starts are ignored.
4. Start a=12, b=5; assert rst in the 2nd RUN cycle -> immediately ready=1, diff=0, bout=0, no done pulse. After release, a=12, b=5 -> diff=7, bout=0.
5. Back-to-back: assert start in the first cycle ready returns high, with a=1, b=2 -> previous diff/bout held until the new done; then diff=4'hF, bout=1.
6. Exhaustive sweep at WIDTH=4 (all a, b, bin) plus 1000 random vectors at WIDTH=16 -> {bout,diff} matches the reference model (a - b - bin) on every done pulse, with done-to-start spacing always WIDTH+1.
